// File: rtl/regfile_write_arbiter_pkg.sv
// Shared definitions for the register-file write arbiter and the writeback stages that feed it.
package regfile_write_arbiter_pkg;

    localparam int              REG_ADDR_W = 5;
    localparam logic [4:0]      REG_ZERO   = 5'd0;
    localparam int              NREQ_MIN   = 2;
    localparam int              NREQ_MAX   = 4;
    localparam int              DW_DEFAULT = 64;

    // Writeback request bundle; the field is called rd because "reg" is a keyword.
    typedef struct packed {
        logic                    valid;
        logic [REG_ADDR_W-1:0]   rd;
        logic [DW_DEFAULT-1:0]   data;
    } wr_req_t;

    function automatic logic nreq_legal(input int n);
        return (n >= NREQ_MIN) && (n <= NREQ_MAX);
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// Parametric round-robin grant generator: first set request at or after ptr, wrapping modulo N.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_idx
);

    logic [IW-1:0] w_cand;
    logic          w_found;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_cand  = '0;
        w_found = 1'b0;
        for (int k = 0; k < N; k++) begin
            w_cand = IW'((int'(i_ptr) + k) % N);
            if (!w_found && i_req[w_cand]) begin
                o_grant[w_cand] = 1'b1;
                o_idx           = w_cand;
                w_found         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin sharing of the register-file write port with a one-cycle registered write stage.
// Define REGFILE_WRITE_ARBITER_FWD_EN to add the forwarding ports for the in-flight write.
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int DW   = 64,
    parameter int CW   = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [REG_ADDR_W*NREQ-1:0] req_reg,
    input  logic [DW*NREQ-1:0]         req_data,
    output logic [NREQ-1:0]            req_ready,
    output logic                       RegWrite,
    output logic [REG_ADDR_W-1:0]      WriteReg,
    output logic [DW-1:0]              WriteData,
    output logic [CW-1:0]              stall_cnt
`ifdef REGFILE_WRITE_ARBITER_FWD_EN
    ,
    input  logic [REG_ADDR_W-1:0]      fwd_rs1,
    input  logic [REG_ADDR_W-1:0]      fwd_rs2,
    output logic                       fwd_hit1,
    output logic                       fwd_hit2,
    output logic [DW-1:0]              fwd_data1,
    output logic [DW-1:0]              fwd_data2
`endif
);

    localparam int PW = $clog2(NREQ);

    if (!nreq_legal(NREQ)) begin : g_bad_nreq
        $fatal(1, "regfile_write_arbiter: NREQ=%0d outside 2..4", NREQ);
    end

    logic [PW-1:0]         r_ptr;
    logic                  r_regwrite;
    logic [REG_ADDR_W-1:0] r_writereg;
    logic [DW-1:0]         r_writedata;
    logic [CW-1:0]         r_stall_cnt;

    logic [NREQ-1:0]       w_grant;
    logic [PW-1:0]         w_gidx;
    logic                  w_xfer;
    logic                  w_stall;
    logic [REG_ADDR_W-1:0] w_sel_reg;
    logic [DW-1:0]         w_sel_data;

    rr_arbiter #(.N(NREQ), .IW(PW)) u_rr (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_gidx)
    );

    assign req_ready  = w_grant;
    assign w_xfer     = |(req_valid & w_grant);
    assign w_stall    = |(req_valid & ~w_grant);
    assign w_sel_reg  = req_reg[REG_ADDR_W*int'(w_gidx) +: REG_ADDR_W];
    assign w_sel_data = req_data[DW*int'(w_gidx) +: DW];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ptr       <= '0;
            r_regwrite  <= 1'b0;
            r_writereg  <= '0;
            r_writedata <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_xfer) begin
                r_ptr       <= (w_gidx == PW'(NREQ-1)) ? '0 : w_gidx + 1'b1;
                // x0 is accepted and consumes a turn but never reaches the register file
                r_regwrite  <= (w_sel_reg != REG_ZERO);
                r_writereg  <= w_sel_reg;
                r_writedata <= w_sel_data;
            end else begin
                r_regwrite  <= 1'b0;
            end
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign RegWrite  = r_regwrite;
    assign WriteReg  = r_writereg;
    assign WriteData = r_writedata;
    assign stall_cnt = r_stall_cnt;

`ifdef REGFILE_WRITE_ARBITER_FWD_EN
    // Covers the cycle where the registered write is not yet committed in the register file.
    assign fwd_hit1  = r_regwrite && (r_writereg == fwd_rs1) && (fwd_rs1 != REG_ZERO);
    assign fwd_hit2  = r_regwrite && (r_writereg == fwd_rs2) && (fwd_rs2 != REG_ZERO);
    assign fwd_data1 = fwd_hit1 ? r_writedata : '0;
    assign fwd_data2 = fwd_hit2 ? r_writedata : '0;
`else
    // No forwarding path in this build.
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with a behavioural register file on the write port.
module tb_regfile_write_arbiter;

    localparam int NREQ = 2;
    localparam int DW   = 64;
    localparam int CW   = 16;
    localparam int CWS  = 3;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic [NREQ-1:0]  req_valid = '0;
    logic [5*NREQ-1:0] req_reg  = '0;
    logic [DW*NREQ-1:0] req_data = '0;

    logic [NREQ-1:0]  req_ready;
    logic             RegWrite;
    logic [4:0]       WriteReg;
    logic [DW-1:0]    WriteData;
    logic [CW-1:0]    stall_cnt;

    logic [NREQ-1:0]  s_ready;
    logic             s_regwrite;
    logic [4:0]       s_writereg;
    logic [DW-1:0]    s_writedata;
    logic [CWS-1:0]   s_stall_cnt;

`ifdef REGFILE_WRITE_ARBITER_FWD_EN
    logic [4:0]       fwd_rs1 = '0;
    logic [4:0]       fwd_rs2 = '0;
    logic             fwd_hit1, fwd_hit2;
    logic [DW-1:0]    fwd_data1, fwd_data2;
    logic [4:0]       s_rs1 = '0;
    logic [4:0]       s_rs2 = '0;
    logic             s_hit1, s_hit2;
    logic [DW-1:0]    s_fdata1, s_fdata2;
`endif

    int errors = 0;
    int checks = 0;

    logic [63:0] rf [32] = '{default: '0};

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (RegWrite) rf[WriteReg] <= WriteData;
    end

    regfile_write_arbiter #(.NREQ(NREQ), .DW(DW), .CW(CW)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_reg   (req_reg),
        .req_data  (req_data),
        .req_ready (req_ready),
        .RegWrite  (RegWrite),
        .WriteReg  (WriteReg),
        .WriteData (WriteData),
        .stall_cnt (stall_cnt)
`ifdef REGFILE_WRITE_ARBITER_FWD_EN
        ,
        .fwd_rs1   (fwd_rs1),
        .fwd_rs2   (fwd_rs2),
        .fwd_hit1  (fwd_hit1),
        .fwd_hit2  (fwd_hit2),
        .fwd_data1 (fwd_data1),
        .fwd_data2 (fwd_data2)
`endif
    );

    regfile_write_arbiter #(.NREQ(NREQ), .DW(DW), .CW(CWS)) dut_sat (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_reg   (req_reg),
        .req_data  (req_data),
        .req_ready (s_ready),
        .RegWrite  (s_regwrite),
        .WriteReg  (s_writereg),
        .WriteData (s_writedata),
        .stall_cnt (s_stall_cnt)
`ifdef REGFILE_WRITE_ARBITER_FWD_EN
        ,
        .fwd_rs1   (s_rs1),
        .fwd_rs2   (s_rs2),
        .fwd_hit1  (s_hit1),
        .fwd_hit2  (s_hit2),
        .fwd_data1 (s_fdata1),
        .fwd_data2 (s_fdata2)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input logic [4:0] r0, input logic [63:0] d0,
                         input logic [4:0] r1, input logic [63:0] d1);
        req_valid = v;
        req_reg   = {r1, r0};
        req_data  = {d1, d0};
    endtask

    logic [1:0] exp_ready [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [4:0] exp_reg   [4] = '{5'd10, 5'd11, 5'd10, 5'd11};

    initial begin
        drive(2'b00, 5'd0, 64'h0, 5'd0, 64'h0);
        reset = 1'b1;
        tick();
        tick();
        check("rst_regwrite",  RegWrite,  1'b0);
        check("rst_writereg",  WriteReg,  5'd0);
        check("rst_writedata", WriteData, 64'h0);
        check("rst_stall",     stall_cnt, 16'd0);
        check("rst_ready",     req_ready, 2'b00);
        reset = 1'b0;

        // Reset between the transfer edge and the commit edge drops the write
        drive(2'b01, 5'd5, 64'hAA, 5'd0, 64'h0);
        #1 check("t1_ready", req_ready, 2'b01);
        tick();
        check("t1_latched", RegWrite, 1'b1);
        drive(2'b00, 5'd0, 64'h0, 5'd0, 64'h0);
        reset = 1'b1;
        #1;
        check("t1_async_regwrite",  RegWrite,  1'b0);
        check("t1_async_writereg",  WriteReg,  5'd0);
        check("t1_async_writedata", WriteData, 64'h0);
        check("t1_async_stall",     stall_cnt, 16'd0);
        tick();
        check("t1_r5_not_written", rf[5], 64'h0);
        reset = 1'b0;

        // Contention from ptr=0: grants alternate 0,1,0,1
        drive(2'b11, 5'd10, 64'h100, 5'd11, 64'h200);
        for (int i = 0; i < 4; i++) begin
            #1 check($sformatf("t3_ready_%0d", i), req_ready, exp_ready[i]);
            tick();
            check($sformatf("t3_regwrite_%0d", i), RegWrite, 1'b1);
            check($sformatf("t3_writereg_%0d", i), WriteReg, exp_reg[i]);
        end
        check("t3_stall", stall_cnt, 16'd4);
        drive(2'b00, 5'd0, 64'h0, 5'd0, 64'h0);
        #1 check("idle_ready", req_ready, 2'b00);
        tick();
        check("idle_regwrite",   RegWrite,  1'b0);
        check("idle_hold_reg",   WriteReg,  5'd11);
        check("idle_hold_data",  WriteData, 64'h200);
        check("idle_stall_hold", stall_cnt, 16'd4);

        // Single requester 1
        drive(2'b10, 5'd0, 64'h0, 5'd3, 64'h1234);
        #1 check("t2_ready", req_ready, 2'b10);
        tick();
        check("t2_regwrite",  RegWrite,  1'b1);
        check("t2_writereg",  WriteReg,  5'd3);
        check("t2_writedata", WriteData, 64'h1234);
        check("t2_stall",     stall_cnt, 16'd4);

        // x0 write is accepted, advances ptr, never writes
        drive(2'b01, 5'd0, 64'hFFFF, 5'd0, 64'h0);
        #1 check("t4_ready", req_ready, 2'b01);
        tick();
        check("t4_regwrite",  RegWrite,  1'b0);
        check("t4_writereg",  WriteReg,  5'd0);
        check("t4_writedata", WriteData, 64'hFFFF);
        drive(2'b11, 5'd13, 64'h77, 5'd12, 64'h3C);
        #1 check("t4_ptr_is_1", req_ready, 2'b10);
        tick();
        check("t4_regwrite2", RegWrite,  1'b1);
        check("t4_writereg2", WriteReg,  5'd12);
        check("t4_stall",     stall_cnt, 16'd5);
        drive(2'b00, 5'd0, 64'h0, 5'd0, 64'h0);
        tick();
        check("t4_r0_clean", rf[0],  64'h0);
        check("t4_r12",      rf[12], 64'h3C);

        // Same destination from both requesters: RR order, later grant wins
        drive(2'b11, 5'd7, 64'h11, 5'd7, 64'h22);
        #1 check("t5_ready0", req_ready, 2'b01);
        tick();
        check("t5_data0", WriteData, 64'h11);
        check("t5_reg0",  WriteReg,  5'd7);
        drive(2'b10, 5'd7, 64'h11, 5'd7, 64'h22);
        #1 check("t5_ready1", req_ready, 2'b10);
        tick();
        check("t5_rf_first", rf[7],     64'h11);
        check("t5_data1",    WriteData, 64'h22);
        drive(2'b00, 5'd0, 64'h0, 5'd0, 64'h0);
        tick();
        check("t5_rf_final", rf[7],     64'h22);
        check("t5_stall",    stall_cnt, 16'd6);

        // Narrow counter saturates at all-ones while the wide one keeps counting
        check("sat_start", s_stall_cnt, 3'd6);
        drive(2'b11, 5'd1, 64'h1, 5'd2, 64'h2);
        #1 check("sat_ready0", s_ready, 2'b01);
        tick();
        check("sat_at_max",  s_stall_cnt, 3'd7);
        check("wide_7",      stall_cnt,   16'd7);
        tick();
        check("sat_hold",    s_stall_cnt, 3'd7);
        check("wide_8",      stall_cnt,   16'd8);
        check("sat_regwrite", s_regwrite,  1'b1);
        check("sat_writereg", s_writereg,  5'd2);
        check("sat_writedata", s_writedata, 64'h2);
        drive(2'b00, 5'd0, 64'h0, 5'd0, 64'h0);
        tick();

`ifdef REGFILE_WRITE_ARBITER_FWD_EN
        drive(2'b01, 5'd9, 64'h55, 5'd0, 64'h0);
        tick();
        drive(2'b00, 5'd0, 64'h0, 5'd0, 64'h0);
        fwd_rs1 = 5'd9;
        fwd_rs2 = 5'd0;
        s_rs1   = 5'd0;
        s_rs2   = 5'd9;
        #1;
        check("t6_hit1",  fwd_hit1,  1'b1);
        check("t6_data1", fwd_data1, 64'h55);
        check("t6_hit2",  fwd_hit2,  1'b0);
        check("t6_data2", fwd_data2, 64'h0);
        check("t6_s_hit1",  s_hit1,   1'b0);
        check("t6_s_data1", s_fdata1, 64'h0);
        check("t6_s_hit2",  s_hit2,   1'b1);
        check("t6_s_data2", s_fdata2, 64'h55);
        tick();
        check("t6_hit1_after", fwd_hit1, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
